// File: rtl/demux_1to3_16bit_reg.sv
// One-hot 1:3 write demux into N/K/M holding registers.
// Tracks per-register fresh flags and reports when a complete operand set is loaded.
module demux_1to3_16bit_reg #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic [2:0]       i_dsel,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_out_n,
  output logic [WIDTH-1:0] o_out_k,
  output logic [WIDTH-1:0] o_out_m,
  output logic             o_wr_n,
  output logic             o_wr_k,
  output logic             o_wr_m,
  output logic [2:0]       o_loaded,
  output logic             o_all_loaded,
  output logic             o_sel_err
);

  // state   | meaning
  // EMPTY   | no register holds fresh data
  // PARTIAL | one or two registers loaded
  // FULL    | all three loaded, writes stalled until clr
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_out_n, r_out_k, r_out_m;
  logic [2:0]       r_loaded, w_loaded_next;
  logic [2:0]       r_stb, r_wr;
  logic             r_sel_err;
  logic             w_onehot, w_attempt, w_accept, w_illegal;

  assign o_din_ready = !i_rst && (r_state != FULL);
  assign w_onehot    = (i_dsel == 3'b001) || (i_dsel == 3'b010) || (i_dsel == 3'b100);
  // clr takes priority over any write in the same cycle
  assign w_attempt   = i_din_valid && o_din_ready && !i_clr;
  assign w_accept    = w_attempt && w_onehot;
  assign w_illegal   = w_attempt && !w_onehot;

  always_comb begin
    w_loaded_next = r_loaded;
    w_state_next  = r_state;
    if (i_clr) begin
      w_loaded_next = 3'b000;
    end else if (w_accept) begin
      w_loaded_next = r_loaded | i_dsel;
    end
    case (w_loaded_next)
      3'b000:  w_state_next = EMPTY;
      3'b111:  w_state_next = FULL;
      default: w_state_next = PARTIAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= EMPTY;
      r_loaded <= 3'b000;
    end else begin
      r_state  <= w_state_next;
      r_loaded <= w_loaded_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_out_n <= RESET_VAL;
      r_out_k <= RESET_VAL;
      r_out_m <= RESET_VAL;
    end else if (w_accept) begin
      if (i_dsel[0]) r_out_n <= i_din;
      if (i_dsel[1]) r_out_k <= i_din;
      if (i_dsel[2]) r_out_m <= i_din;
    end
  end

  // Strobe trails the register update by one cycle: r_stb marks the update, r_wr reports it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stb     <= 3'b000;
      r_wr      <= 3'b000;
      r_sel_err <= 1'b0;
    end else begin
      r_stb <= w_accept ? i_dsel : 3'b000;
      r_wr  <= r_stb;
      if (w_illegal) r_sel_err <= 1'b1;
    end
  end

  assign o_out_n      = r_out_n;
  assign o_out_k      = r_out_k;
  assign o_out_m      = r_out_m;
  assign o_wr_n       = r_wr[0];
  assign o_wr_k       = r_wr[1];
  assign o_wr_m       = r_wr[2];
  assign o_loaded     = r_loaded;
  assign o_all_loaded = (r_state == FULL);
  assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_demux_1to3_16bit_reg.sv
// Directed bench for demux_1to3_16bit_reg with hand-computed expectations.
module tb_demux_1to3_16bit_reg;
  logic        clk = 1'b0;
  logic        rst, din_valid, clr;
  logic [15:0] din;
  logic [2:0]  dsel;
  logic        din_ready, wr_n, wr_k, wr_m, all_loaded, sel_err;
  logic [15:0] out_n, out_k, out_m;
  logic [2:0]  loaded;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  demux_1to3_16bit_reg #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_dsel(dsel), .i_din_valid(din_valid),
    .o_din_ready(din_ready), .i_clr(clr), .o_out_n(out_n), .o_out_k(out_k),
    .o_out_m(out_m), .o_wr_n(wr_n), .o_wr_k(wr_k), .o_wr_m(wr_m),
    .o_loaded(loaded), .o_all_loaded(all_loaded), .o_sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [15:0] d, input logic c);
    din_valid = v;
    dsel      = s;
    din       = d;
    clr       = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 3'b001, 16'hFFFF, 1'b0);
    #1;
    chk("ready_in_rst", din_ready, 0);
    tick();
    chk("ready_in_rst2", din_ready, 0);
    tick();
    chk("rst_outs", {out_n, out_k}, 32'h0);
    chk("rst_out_m", out_m, 0);
    chk("rst_loaded", loaded, 3'b000);
    chk("rst_wr", {wr_m, wr_k, wr_n}, 3'b000);
    chk("rst_sel_err", sel_err, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", din_ready, 1);

    // fill N, K, M on consecutive cycles
    drive(1'b1, 3'b001, 16'h1234, 1'b0);
    tick();
    chk("fill_out_n", out_n, 16'h1234);
    chk("fill_loaded1", loaded, 3'b001);
    chk("fill_wr1", {wr_m, wr_k, wr_n}, 3'b000);
    drive(1'b1, 3'b010, 16'hBEEF, 1'b0);
    tick();
    chk("fill_out_k", out_k, 16'hBEEF);
    chk("fill_loaded2", loaded, 3'b011);
    chk("fill_wr2", {wr_m, wr_k, wr_n}, 3'b001);
    chk("fill_all2", all_loaded, 0);
    drive(1'b1, 3'b100, 16'h00FF, 1'b0);
    tick();
    chk("fill_out_m", out_m, 16'h00FF);
    chk("fill_loaded3", loaded, 3'b111);
    chk("fill_all3", all_loaded, 1);
    chk("fill_ready3", din_ready, 0);
    chk("fill_wr3", {wr_m, wr_k, wr_n}, 3'b010);

    // full stall
    drive(1'b1, 3'b001, 16'hAAAA, 1'b0);
    tick();
    chk("stall_out_n", out_n, 16'h1234);
    chk("stall_wr4", {wr_m, wr_k, wr_n}, 3'b100);
    tick();
    chk("stall_out_n2", out_n, 16'h1234);
    chk("stall_wr5", {wr_m, wr_k, wr_n}, 3'b000);
    chk("stall_sel_err", sel_err, 0);
    drive(1'b0, 3'b000, 16'h0000, 1'b1);
    tick();
    chk("clr_loaded", loaded, 3'b000);
    chk("clr_outs", {out_n, out_k}, 32'h0);
    chk("clr_out_m", out_m, 0);
    chk("clr_ready", din_ready, 1);
    chk("clr_all", all_loaded, 0);

    // illegal select
    drive(1'b1, 3'b011, 16'h5555, 1'b0);
    tick();
    chk("ill_sel_err", sel_err, 1);
    chk("ill_loaded", loaded, 3'b000);
    chk("ill_outs", {out_n, out_k}, 32'h0);
    drive(1'b1, 3'b000, 16'h5555, 1'b0);
    tick();
    chk("ill0_sel_err", sel_err, 1);
    chk("ill0_loaded", loaded, 3'b000);
    chk("ill_wr", {wr_m, wr_k, wr_n}, 3'b000);
    drive(1'b0, 3'b000, 16'h0000, 1'b1);
    tick();
    chk("ill_clr_sel_err", sel_err, 1);

    // overwrite K twice
    drive(1'b1, 3'b010, 16'h0001, 1'b0);
    tick();
    chk("ow_k1", out_k, 16'h0001);
    chk("ow_loaded1", loaded, 3'b010);
    drive(1'b1, 3'b010, 16'h0002, 1'b0);
    tick();
    chk("ow_k2", out_k, 16'h0002);
    chk("ow_wr_a", {wr_m, wr_k, wr_n}, 3'b010);
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    tick();
    chk("ow_wr_b", {wr_m, wr_k, wr_n}, 3'b010);
    chk("ow_loaded2", loaded, 3'b010);
    chk("ow_partial", {all_loaded, din_ready}, 2'b01);
    chk("ow_out_n", out_n, 16'h0000);
    tick();
    chk("ow_wr_c", {wr_m, wr_k, wr_n}, 3'b000);

    // clr and write in the same cycle
    drive(1'b1, 3'b100, 16'h7777, 1'b1);
    tick();
    chk("sim_out_m", out_m, 16'h0000);
    chk("sim_out_k", out_k, 16'h0000);
    chk("sim_loaded", loaded, 3'b000);
    chk("sim_sel_err", sel_err, 1);
    drive(1'b0, 3'b000, 16'h0000, 1'b0);
    tick();
    chk("sim_wr1", {wr_m, wr_k, wr_n}, 3'b000);
    tick();
    chk("sim_wr2", {wr_m, wr_k, wr_n}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
